// File: rtl/rice_inst_decode_stage.sv
// RV32I/RV64I instruction-decode stage: classifies {pc, inst}, extracts fields and a
// sign-extended immediate, and registers the result behind a valid/ready skid buffer.
module rice_inst_decode_stage #(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = XLEN
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [PC_WIDTH-1:0] i_pc,
  input  logic [31:0]         i_inst,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [6:0]          o_opcode,
  output logic [2:0]          o_inst_type,
  output logic [4:0]          o_rs1,
  output logic [4:0]          o_rs2,
  output logic [4:0]          o_rd,
  output logic [2:0]          o_funct3,
  output logic [6:0]          o_funct7,
  output logic [XLEN-1:0]     o_imm,
  output logic                o_illegal
);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] TYPE_R = 3'd0;
  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_B = 3'd3;
  localparam logic [2:0] TYPE_U = 3'd4;
  localparam logic [2:0] TYPE_J = 3'd5;

  // Widen a 32-bit immediate to XLEN by replicating bit 31.
  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    logic signed [XLEN-1:0] r;
    r = v;
    return r;
  endfunction

  logic                skid_vld;
  logic [PC_WIDTH-1:0] skid_pc;
  logic [31:0]         skid_inst;

  logic                vld_p1;
  logic [PC_WIDTH-1:0] pc_p1;
  logic [6:0]          opcode_p1;
  logic [2:0]          type_p1;
  logic [4:0]          rs1_p1, rs2_p1, rd_p1;
  logic [2:0]          funct3_p1;
  logic [6:0]          funct7_p1;
  logic [XLEN-1:0]     imm_p1;
  logic                illegal_p1;

  logic                accept;
  logic                load_out;
  logic [PC_WIDTH-1:0] src_pc;
  logic [31:0]         src_inst;

  logic [2:0]          type_p0;
  logic [4:0]          rs1_p0, rs2_p0, rd_p0;
  logic [2:0]          funct3_p0;
  logic [6:0]          funct7_p0;
  logic signed [31:0]  imm32_p0;
  logic                illegal_p0;

  assign o_ready  = !skid_vld;
  assign accept   = i_valid && !skid_vld;
  assign load_out = !vld_p1 || i_ready;
  // A full skid buffer is always older than the live input, so it feeds the output first.
  assign src_pc   = skid_vld ? skid_pc   : i_pc;
  assign src_inst = skid_vld ? skid_inst : i_inst;

  // ---- stage p0: combinational decode of the selected source ----
  always_comb begin
    type_p0    = TYPE_R;
    rs1_p0     = '0;
    rs2_p0     = '0;
    rd_p0      = '0;
    funct3_p0  = '0;
    funct7_p0  = '0;
    imm32_p0   = '0;
    illegal_p0 = 1'b0;
    case (src_inst[6:0])
      OPC_OP: begin
        rs1_p0    = src_inst[19:15];
        rs2_p0    = src_inst[24:20];
        rd_p0     = src_inst[11:7];
        funct3_p0 = src_inst[14:12];
        funct7_p0 = src_inst[31:25];
      end
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
        type_p0   = TYPE_I;
        rs1_p0    = src_inst[19:15];
        rd_p0     = src_inst[11:7];
        funct3_p0 = src_inst[14:12];
        imm32_p0  = {{20{src_inst[31]}}, src_inst[31:20]};
      end
      OPC_STORE: begin
        type_p0   = TYPE_S;
        rs1_p0    = src_inst[19:15];
        rs2_p0    = src_inst[24:20];
        funct3_p0 = src_inst[14:12];
        imm32_p0  = {{20{src_inst[31]}}, src_inst[31:25], src_inst[11:7]};
      end
      OPC_BRANCH: begin
        type_p0   = TYPE_B;
        rs1_p0    = src_inst[19:15];
        rs2_p0    = src_inst[24:20];
        funct3_p0 = src_inst[14:12];
        imm32_p0  = {{19{src_inst[31]}}, src_inst[31], src_inst[7],
                     src_inst[30:25], src_inst[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        type_p0  = TYPE_U;
        rd_p0    = src_inst[11:7];
        imm32_p0 = {src_inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        type_p0  = TYPE_J;
        rd_p0    = src_inst[11:7];
        imm32_p0 = {{11{src_inst[31]}}, src_inst[31], src_inst[19:12],
                    src_inst[20], src_inst[30:21], 1'b0};
      end
      // Any opcode outside the base set, including inst[1:0] != 2'b11, lands here.
      default: illegal_p0 = 1'b1;
    endcase
  end

  // ---- stage p1: control for output register and skid buffer ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1   <= 1'b0;
      skid_vld <= 1'b0;
    end else if (i_flush) begin
      vld_p1   <= 1'b0;
      skid_vld <= 1'b0;
    end else if (load_out) begin
      vld_p1   <= skid_vld || accept;
      skid_vld <= 1'b0;
    end else if (accept) begin
      skid_vld <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      skid_pc    <= '0;
      skid_inst  <= '0;
      pc_p1      <= '0;
      opcode_p1  <= '0;
      type_p1    <= TYPE_R;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      rd_p1      <= '0;
      funct3_p1  <= '0;
      funct7_p1  <= '0;
      imm_p1     <= '0;
      illegal_p1 <= 1'b0;
    end else if (!i_flush) begin
      if (load_out && (skid_vld || accept)) begin
        pc_p1      <= src_pc;
        opcode_p1  <= src_inst[6:0];
        type_p1    <= type_p0;
        rs1_p1     <= rs1_p0;
        rs2_p1     <= rs2_p0;
        rd_p1      <= rd_p0;
        funct3_p1  <= funct3_p0;
        funct7_p1  <= funct7_p0;
        imm_p1     <= sext32(imm32_p0);
        illegal_p1 <= illegal_p0;
      end
      if (!load_out && accept) begin
        skid_pc   <= i_pc;
        skid_inst <= i_inst;
      end
    end
  end

  assign o_valid     = vld_p1;
  assign o_pc        = pc_p1;
  assign o_opcode    = opcode_p1;
  assign o_inst_type = type_p1;
  assign o_rs1       = rs1_p1;
  assign o_rs2       = rs2_p1;
  assign o_rd        = rd_p1;
  assign o_funct3    = funct3_p1;
  assign o_funct7    = funct7_p1;
  assign o_imm       = imm_p1;
  assign o_illegal   = illegal_p1;

endmodule

// File: tb/tb_rice_inst_decode_stage.sv
// Directed bench for rice_inst_decode_stage: decode table at XLEN=32/64, backpressure,
// flush and mid-stream reset.
module tb_rice_inst_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;

  logic        rdy, vld;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [2:0]  itype;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm;
  logic        ill;

  logic        rdy64, vld64;
  logic [63:0] pc64;
  logic [6:0]  opcode64;
  logic [2:0]  itype64;
  logic [4:0]  rs1_64, rs2_64, rd64;
  logic [2:0]  f3_64;
  logic [6:0]  f7_64;
  logic [63:0] imm64;
  logic        ill64;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rice_inst_decode_stage #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(rdy),
    .i_pc(in_pc), .i_inst(in_inst), .o_valid(vld), .i_ready(in_ready), .o_pc(pc),
    .o_opcode(opcode), .o_inst_type(itype), .o_rs1(rs1), .o_rs2(rs2), .o_rd(rd),
    .o_funct3(f3), .o_funct7(f7), .o_imm(imm), .o_illegal(ill)
  );

  rice_inst_decode_stage #(.XLEN(64)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(rdy64),
    .i_pc({32'h0, in_pc}), .i_inst(in_inst), .o_valid(vld64), .i_ready(in_ready), .o_pc(pc64),
    .o_opcode(opcode64), .o_inst_type(itype64), .o_rs1(rs1_64), .o_rs2(rs2_64), .o_rd(rd64),
    .o_funct3(f3_64), .o_funct7(f7_64), .o_imm(imm64), .o_illegal(ill64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  t;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic        ill;
  } vec_t;

  vec_t tbl [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{32'hfff10093, 3'd1, 5'd2, 5'd0, 5'd1, 3'd0, 7'h00, 32'hffffffff, 64'hffffffffffffffff, 1'b0};
    tbl[1] = '{32'h00532423, 3'd2, 5'd6, 5'd5, 5'd0, 3'd2, 7'h00, 32'h00000008, 64'h0000000000000008, 1'b0};
    tbl[2] = '{32'hfe000ee3, 3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hfffffffc, 64'hfffffffffffffffc, 1'b0};
    tbl[3] = '{32'h123451b7, 3'd4, 5'd0, 5'd0, 5'd3, 3'd0, 7'h00, 32'h12345000, 64'h0000000012345000, 1'b0};
    tbl[4] = '{32'h001000ef, 3'd5, 5'd0, 5'd0, 5'd1, 3'd0, 7'h00, 32'h00000800, 64'h0000000000000800, 1'b0};
    tbl[5] = '{32'h800000b7, 3'd4, 5'd0, 5'd0, 5'd1, 3'd0, 7'h00, 32'h80000000, 64'hffffffff80000000, 1'b0};
    tbl[6] = '{32'h00000000, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 64'h0000000000000000, 1'b1};
    tbl[7] = '{32'h402081b3, 3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'h00000000, 64'h0000000000000000, 1'b0};
    tbl[8] = '{32'h0000007f, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 64'h0000000000000000, 1'b1};
    tbl[9] = '{32'hff812283, 3'd1, 5'd2, 5'd0, 5'd5, 3'd2, 7'h00, 32'hfffffff8, 64'hfffffffffffffff8, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ready = 1'b1;
    in_pc = '0; in_inst = '0;
    step();
    chk("rst_valid", vld, 0);
    chk("rst_type", itype, 0);
    chk("rst_imm", imm, 0);
    chk("rst_pc", pc, 0);
    step();
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("post_rst_ready", rdy, 1);
    chk("post_rst_valid", vld, 0);

    // Back-to-back decode stream, one entry per cycle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_pc    = 32'h1000 + 32'(i * 4);
      in_inst  = tbl[i].inst;
      step();
      chk($sformatf("v%0d_valid", i), vld, 1);
      chk($sformatf("v%0d_ready", i), rdy, 1);
      chk($sformatf("v%0d_pc", i), pc, 32'h1000 + 32'(i * 4));
      chk($sformatf("v%0d_opcode", i), opcode, tbl[i].inst[6:0]);
      chk($sformatf("v%0d_type", i), itype, tbl[i].t);
      chk($sformatf("v%0d_rs1", i), rs1, tbl[i].rs1);
      chk($sformatf("v%0d_rs2", i), rs2, tbl[i].rs2);
      chk($sformatf("v%0d_rd", i), rd, tbl[i].rd);
      chk($sformatf("v%0d_f3", i), f3, tbl[i].f3);
      chk($sformatf("v%0d_f7", i), f7, tbl[i].f7);
      chk($sformatf("v%0d_imm", i), imm, tbl[i].imm32);
      chk($sformatf("v%0d_ill", i), ill, tbl[i].ill);
      chk($sformatf("v%0d_imm64", i), imm64, tbl[i].imm64);
      chk($sformatf("v%0d_valid64", i), vld64, 1);
    end
    @(negedge clk); in_valid = 1'b0;
    step();
    chk("drain_valid", vld, 0);

    // Backpressure: A on output, B into skid, C stalled.
    @(negedge clk); in_ready = 1'b0; in_valid = 1'b1; in_pc = 32'hA0; in_inst = 32'h00100093;
    step();
    chk("bp_a_valid", vld, 1);
    chk("bp_a_pc", pc, 32'hA0);
    @(negedge clk); in_pc = 32'hB0; in_inst = 32'h00200113;
    step();
    chk("bp_skid_ready", rdy, 0);
    chk("bp_hold_a_pc", pc, 32'hA0);
    chk("bp_hold_a_rd", rd, 1);
    @(negedge clk); in_pc = 32'hC0; in_inst = 32'h00300193;
    step();
    chk("bp_stall_ready", rdy, 0);
    chk("bp_stall_pc", pc, 32'hA0);
    @(negedge clk); in_ready = 1'b1;
    step();
    chk("bp_b_valid", vld, 1);
    chk("bp_b_pc", pc, 32'hB0);
    chk("bp_b_rd", rd, 2);
    chk("bp_b_ready", rdy, 1);
    step();
    @(negedge clk); in_valid = 1'b0;
    chk("bp_c_valid", vld, 1);
    chk("bp_c_pc", pc, 32'hC0);
    chk("bp_c_rd", rd, 3);
    step();
    chk("bp_end_valid", vld, 0);

    // Flush with A on output, B in skid and C presented in the flush cycle.
    @(negedge clk); in_ready = 1'b0; in_valid = 1'b1; in_pc = 32'hA4; in_inst = 32'h00100093;
    step();
    @(negedge clk); in_pc = 32'hB4; in_inst = 32'h00200113;
    step();
    chk("fl_pre_ready", rdy, 0);
    @(negedge clk); in_pc = 32'hC4; in_inst = 32'h00300193; flush = 1'b1;
    step();
    chk("fl_valid", vld, 0);
    chk("fl_ready", rdy, 1);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; in_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("fl_quiet%0d", k), vld, 0);
    end
    // Flush while o_ready=1: the presented entry is dropped.
    @(negedge clk); in_valid = 1'b1; in_pc = 32'hD4; flush = 1'b1;
    step();
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    chk("fl_rdy_drop", vld, 0);

    // Asynchronous reset in the middle of a stream.
    @(negedge clk); in_valid = 1'b1; in_pc = 32'hE0; in_inst = 32'hfff10093;
    step();
    chk("mr_pre_valid", vld, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_valid", vld, 0);
    chk("mr_pc", pc, 0);
    chk("mr_imm", imm, 0);
    chk("mr_rd", rd, 0);
    @(negedge clk); rst_n = 1'b1; in_pc = 32'hF0; in_inst = 32'h123451b7;
    #1;
    chk("mr_before_accept", vld, 0);
    step();
    @(negedge clk); in_valid = 1'b0;
    chk("mr_first_valid", vld, 1);
    chk("mr_first_pc", pc, 32'hF0);
    chk("mr_first_imm", imm, 32'h12345000);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rice_inst_decode_stage.md
Name: rice_inst_decode_stage

Overview:
- Registered RV32I/RV64I instruction-decode pipeline stage between fetch and execute.
- Accepts {pc, inst} over a valid/ready handshake and classifies the opcode into instruction type (R/I/S/B/U/J).
- Extracts register indices, funct fields and a sign-extended XLEN-wide immediate, and flags illegal encodings.
- Sustains full throughput under downstream backpressure via a one-entry skid buffer; supports pipeline flush.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; sets o_imm width.
- PC_WIDTH, XLEN, width of i_pc/o_pc.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_flush  input  1  discard all in-flight entries
- i_valid  input  1  upstream entry valid
- o_ready  output  1  stage can accept an entry
- i_pc  input  PC_WIDTH  instruction address
- i_inst  input  32  raw instruction word
- o_valid  output  1  decoded entry valid
- i_ready  input  1  downstream accepts entry
- o_pc  output  PC_WIDTH  pc of decoded entry
- o_opcode  output  7  inst[6:0]
- o_inst_type  output  3  R=0, I=1, S=2, B=3, U=4, J=5
- o_rs1 / o_rs2 / o_rd  output  5 each  register indices, zeroed when unused
- o_funct3  output  3  inst[14:12]; 0 for U/J
- o_funct7  output  7  inst[31:25]; R type only, else 0
- o_imm  output  XLEN  sign-extended immediate
- o_illegal  output  1  unsupported encoding

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: o_valid=0; all data outputs 0 (o_inst_type=R); skid buffer empty; o_ready=1 from the first cycle after reset release.
- Decode is combinational from the input, registered into the output stage. Latency is 1 cycle from accept (i_valid&&o_ready) to o_valid.
- Type map:
  - LOAD, OP_IMM, JALR, MISC_MEM, SYSTEM -> I
  - STORE -> S
  - BRANCH -> B
  - LUI, AUIPC -> U
  - JAL -> J
  - OP and all others -> R
- Register fields:
  - rs1 used by R/I/S/B.
  - rs2 used by R/S/B.
  - rd used by R/I/U/J.
  - Unused fields output 0.
- Immediates, sign bit inst[31] extended to XLEN:
  - I = inst[31:20]
  - S = {inst[31:25], inst[11:7]}
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U = {inst[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R = 0
- Illegal: o_illegal=1 when inst[1:0]!=2'b11 or opcode is not one of the 11 base opcodes. An illegal entry still flows with type R, all fields 0 and imm 0.
- Handshake:
  - Output register loads when it is empty or i_ready=1. Source is the skid buffer if full, else the input.
  - An input accepted while o_valid=1 and i_ready=0 goes to the skid buffer.
  - o_ready = !skid_valid (registered, no combinational path from i_ready).
  - Order preserved. No entry is dropped or duplicated.
  - Output data stays stable while o_valid&&!i_ready.
- Full throughput: with i_valid=i_ready=1 continuously, one entry per cycle.
- Flush: i_flush=1 clears o_valid and skid_valid next cycle. An input presented in the flush cycle is discarded even if o_ready=1. Flush has priority over accept and over skid transfer.
- Reset mid-operation: all valids clear immediately (asynchronously); no entry survives.

Test Plan:
- i_inst=0xfff10093 (addi x1,x2,-1) -> next cycle: type I, rs1=2, rd=1, rs2=0, funct3=0, imm=0xffffffff, illegal=0.
- Store/branch/lui/jal -> S/B/U/J decodes:
  - 0x00532423 (sw x5,8(x6)) -> S, rs1=6, rs2=5, rd=0, imm=8.
  - 0xfe000ee3 (beq -4) -> B, imm=0xfffffffc.
  - 0x123451b7 (lui x3) -> U, rd=3, imm=0x12345000.
  - 0x001000ef (jal x1,2048) -> J, rd=1, imm=0x800.
- XLEN=64, i_inst=0x800000b7 -> imm=0xffffffff80000000. i_inst=0x00000000 -> illegal=1, all fields 0.
- Backpressure:
  - Stream A,B,C with i_ready=0 -> A held on output, B in skid, o_ready=0, C stalled.
  - Then i_ready=1 -> A,B,C emitted in order on consecutive cycles.
- i_flush with A on output and B in skid, plus C presented same cycle -> next cycle o_valid=0, o_ready=1, C never emitted.
- i_rst_n asserted mid-stream -> o_valid=0 and outputs 0 immediately; first post-reset input appears 1 cycle after accept.
